// File: rtl/tlight_pkg.sv
// Shared traffic-light types: light encodings and the
// east/west request FSM states, used by controller and front-end.
package tlight_pkg;

  typedef enum logic [2:0] {
    OFF,
    RED,
    YELLOW,
    GREEN,
    PRE_GREEN
  } lights_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVED
  } ew_req_state_t;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tl_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer:
// the output follows the input only after a stable mismatch run.
module tl_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // bring the asynchronous level into the clk domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // count consecutive mismatches; a match restarts the run
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (s2 == filt) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      filt <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tl_sensor_conditioner.sv
// Sensor front-end: filters loop and transponder inputs, latches
// east/west requests until GREEN, and stretches emergency requests.
module tl_sensor_conditioner
  import tlight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EMGCY_HOLD      = 8,
  parameter int REQ_TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ew_loop_raw,
  input  logic       emgcy_raw,
  input  lights_t    ew_light,
  input  lights_t    ns_light,
  output logic       ew_sensor,
  output logic       emgcy_sensor,
  output logic       ew_req_pending,
  output logic       req_timeout_err,
  output logic [7:0] served_count
);

  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(REQ_TIMEOUT - 1);
  localparam int HW = $clog2(EMGCY_HOLD + 1);
  localparam logic [HW-1:0] HLOAD = HW'(EMGCY_HOLD);

  logic          loop_f;
  logic          emgcy_f;
  logic          emgcy_f_q;

  ew_req_state_t state;
  ew_req_state_t state_next;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_next;
  logic          err_next;
  logic [7:0]    cnt_next;

  logic [HW-1:0] hold;
  logic [HW-1:0] hold_next;
  logic          emgcy_next;

  tl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_loop_db (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (ew_loop_raw),
    .filt   (loop_f)
  );

  tl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_emgcy_db (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (emgcy_raw),
    .filt   (emgcy_f)
  );

  // request FSM next state, timeout counting and served tally
  always_comb begin
    state_next = state;
    tcnt_next  = tcnt;
    err_next   = 1'b0;
    cnt_next   = served_count;
    unique case (state)
      IDLE: begin
        tcnt_next = '0;
        if (loop_f) state_next = REQ;
      end
      REQ: begin
        if (ew_light == GREEN) begin
          state_next = SERVED;
          tcnt_next  = '0;
          cnt_next   = sat_inc8(served_count);
        end else if (!emgcy_sensor) begin
          if (tcnt == TLAST) begin
            tcnt_next = '0;
            err_next  = 1'b1;
          end else begin
            tcnt_next = tcnt + 1'b1;
          end
        end
      end
      SERVED: begin
        tcnt_next = '0;
        if (ew_light != GREEN) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        tcnt_next  = '0;
      end
    endcase
  end

  // register FSM state and all request-side outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      tcnt            <= '0;
      ew_sensor       <= 1'b0;
      ew_req_pending  <= 1'b0;
      req_timeout_err <= 1'b0;
      served_count    <= '0;
    end else begin
      state           <= state_next;
      tcnt            <= tcnt_next;
      ew_sensor       <= (state_next == REQ);
      ew_req_pending  <= (state_next == REQ);
      req_timeout_err <= err_next;
      served_count    <= cnt_next;
    end
  end

  // emergency stretch: reload on filtered rise, count down to 0
  always_comb begin
    hold_next = hold;
    if (emgcy_f && !emgcy_f_q) begin
      hold_next = HLOAD;
    end else if (hold != '0) begin
      hold_next = hold - 1'b1;
    end
    emgcy_next = emgcy_f || (hold_next != '0);
  end

  // register emergency hold state and output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold         <= '0;
      emgcy_f_q    <= 1'b0;
      emgcy_sensor <= 1'b0;
    end else begin
      hold         <= hold_next;
      emgcy_f_q    <= emgcy_f;
      emgcy_sensor <= emgcy_next;
    end
  end

  // conflict monitor: both approaches must never be GREEN together
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(ew_light == GREEN && ns_light == GREEN));
    end
  end

endmodule

// File: tb/tb_tl_sensor_conditioner.sv
// Bench for tl_sensor_conditioner: directed steps plus random
// stimulus, every cycle compared against a cycle-count model.
module tb_tl_sensor_conditioner;
  import tlight_pkg::*;

  localparam int D = 4;
  localparam int H = 8;
  localparam int T = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ew_loop_raw = 1'b0;
  logic       emgcy_raw = 1'b0;
  lights_t    ew_light = RED;
  lights_t    ns_light = RED;
  logic       ew_sensor;
  logic       emgcy_sensor;
  logic       ew_req_pending;
  logic       req_timeout_err;
  logic [7:0] served_count;

  int n_cmp = 0;
  int n_bad = 0;

  tl_sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .EMGCY_HOLD     (H),
    .REQ_TIMEOUT    (T)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ew_loop_raw    (ew_loop_raw),
    .emgcy_raw      (emgcy_raw),
    .ew_light       (ew_light),
    .ns_light       (ns_light),
    .ew_sensor      (ew_sensor),
    .emgcy_sensor   (emgcy_sensor),
    .ew_req_pending (ew_req_pending),
    .req_timeout_err(req_timeout_err),
    .served_count   (served_count)
  );

  always #5 clk = ~clk;

  // reference model: edge index arithmetic and sample histories
  int e = 0;
  bit ql[$];
  bit qe[$];
  bit hl[$];
  bit he[$];
  bit fl, fe, fe_prev;
  bit pend, srv, emg, m_err;
  int hold_end, waitc, cnt;

  function automatic bit settle(input bit h[$], input bit f);
    if (h.size() < D) return 1'b0;
    foreach (h[i]) if (h[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit sl, se;
    if (!reset_n) begin
      ql.delete(); qe.delete(); hl.delete(); he.delete();
      fl = 0; fe = 0; fe_prev = 0;
      pend = 0; srv = 0; emg = 0; m_err = 0;
      hold_end = 0; waitc = 0; cnt = 0;
      e++;
      return;
    end
    sl = (ql.size() >= 2) ? ql[ql.size()-2] : 1'b0;
    se = (qe.size() >= 2) ? qe[qe.size()-2] : 1'b0;
    m_err = 0;
    if (pend) begin
      if (ew_light == GREEN) begin
        pend = 0; srv = 1;
        if (cnt < 255) cnt++;
      end else if (!emg) begin
        waitc++;
        if (waitc % T == 0) m_err = 1;
      end
    end else if (srv) begin
      if (ew_light != GREEN) srv = 0;
    end else if (fl) begin
      pend = 1; waitc = 0;
    end
    if (fe && !fe_prev) hold_end = e + H;
    fe_prev = fe;
    emg = fe || (e < hold_end);
    hl.push_back(sl);
    if (hl.size() > D) void'(hl.pop_front());
    if (settle(hl, fl)) begin fl = !fl; hl.delete(); end
    he.push_back(se);
    if (he.size() > D) void'(he.pop_front());
    if (settle(he, fe)) begin fe = !fe; he.delete(); end
    ql.push_back(ew_loop_raw);
    if (ql.size() > 2) void'(ql.pop_front());
    qe.push_back(emgcy_raw);
    if (qe.size() > 2) void'(qe.pop_front());
    e++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("ew_sensor", ew_sensor, pend);
    chk("ew_req_pending", ew_req_pending, pend);
    chk("emgcy_sensor", emgcy_sensor, emg);
    chk("req_timeout_err", req_timeout_err, m_err);
    chk("served_count", served_count, cnt);
  endtask

  task automatic do_reset();
    reset_n = 0;
    ew_loop_raw = 0;
    emgcy_raw = 0;
    ew_light = RED;
    repeat (2) cyc();
    reset_n = 1;
  endtask

  task automatic wait_req(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (ew_req_pending) break;
      cyc();
    end
    chk("wait_req", ew_req_pending, 1);
  endtask

  initial begin
    int seen, hi, k, fall, np, p1, p2;
    int lrun, erun, grun;

    // reset with both raw inputs high
    reset_n = 0;
    ew_loop_raw = 1;
    emgcy_raw = 1;
    repeat (3) cyc();
    chk("rst_ew", ew_sensor, 0);
    chk("rst_em", emgcy_sensor, 0);
    chk("rst_cnt", served_count, 0);
    reset_n = 1;
    repeat (6) cyc();
    chk("lat_before_ew", ew_sensor, 0);
    cyc();
    chk("lat_edge6_ew", ew_sensor, 1);
    chk("lat_edge6_em", emgcy_sensor, 1);

    // glitch rejection
    do_reset();
    ew_loop_raw = 1;
    repeat (3) cyc();
    ew_loop_raw = 0;
    seen = 0;
    repeat (12) begin cyc(); seen |= int'(ew_sensor); end
    chk("glitch_ew", seen, 0);
    emgcy_raw = 1;
    repeat (3) cyc();
    emgcy_raw = 0;
    seen = 0;
    repeat (12) begin cyc(); seen |= int'(emgcy_sensor); end
    chk("glitch_em", seen, 0);

    // handshake
    do_reset();
    ew_loop_raw = 1;
    wait_req(20);
    repeat (10) cyc();
    ew_light = GREEN;
    cyc();
    chk("hs_fall", ew_sensor, 0);
    chk("hs_cnt", served_count, 1);
    ew_light = RED;
    cyc();
    chk("hs_idle", ew_req_pending, 0);
    cyc();
    chk("hs_reenter", ew_req_pending, 1);

    // timeout pulses
    do_reset();
    ew_loop_raw = 1;
    wait_req(20);
    k = 0; np = 0; p1 = -1; p2 = -1;
    repeat (130) begin
      cyc();
      k++;
      if (req_timeout_err) begin
        np++;
        if (np == 1) p1 = k;
        if (np == 2) p2 = k;
      end
    end
    chk("to_first", p1, 64);
    chk("to_second", p2, 128);
    chk("to_num", np, 2);

    // timeout frozen under emergency
    do_reset();
    emgcy_raw = 1;
    ew_loop_raw = 1;
    wait_req(20);
    np = 0;
    repeat (130) begin cyc(); np += int'(req_timeout_err); end
    chk("to_frozen", np, 0);
    chk("to_frozen_held", ew_sensor, 1);

    // emergency hold, short pulse
    do_reset();
    emgcy_raw = 1;
    repeat (5) cyc();
    emgcy_raw = 0;
    hi = 0;
    repeat (30) begin cyc(); hi += int'(emgcy_sensor); end
    chk("hold_short", hi, 8);

    // emergency hold, long pulse
    do_reset();
    emgcy_raw = 1;
    repeat (20) cyc();
    chk("hold_long_on", emgcy_sensor, 1);
    emgcy_raw = 0;
    k = 0; fall = -1;
    repeat (30) begin
      cyc();
      k++;
      if (fall < 0 && !emgcy_sensor) fall = k;
    end
    chk("hold_long_fall", fall, 7);

    // GREEN on the timeout cycle
    do_reset();
    ew_loop_raw = 1;
    wait_req(20);
    repeat (63) cyc();
    chk("corner_pre", req_timeout_err, 0);
    ew_light = GREEN;
    cyc();
    chk("corner_err", req_timeout_err, 0);
    chk("corner_cnt", served_count, 1);
    chk("corner_fall", ew_sensor, 0);
    ew_light = RED;
    ew_loop_raw = 0;
    repeat (4) cyc();

    // served_count saturation
    do_reset();
    ew_loop_raw = 1;
    for (int i = 0; i < 256; i++) begin
      wait_req(20);
      ew_light = GREEN;
      cyc();
      ew_light = RED;
      if (i == 254) chk("sat_255", served_count, 255);
      cyc();
    end
    chk("sat_hold", served_count, 255);
    wait_req(20);
    chk("sat_fsm", ew_sensor, 1);

    // randomized traffic
    do_reset();
    lrun = 0; erun = 0; grun = 0;
    for (int i = 0; i < 4000; i++) begin
      if (lrun == 0) begin
        ew_loop_raw = 1'($urandom_range(0, 1));
        lrun = $urandom_range(1, 12);
      end
      if (erun == 0) begin
        emgcy_raw = ($urandom_range(0, 3) == 0);
        erun = $urandom_range(1, 15);
      end
      if (grun == 0) begin
        case ($urandom_range(0, 3))
          0: ew_light = GREEN;
          1: ew_light = YELLOW;
          default: ew_light = RED;
        endcase
        grun = ($urandom_range(0, 4) == 0) ?
               $urandom_range(60, 140) : $urandom_range(1, 20);
      end
      reset_n = ($urandom_range(0, 599) != 0);
      lrun--; erun--; grun--;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
